// File: rtl/fetch_unit.sv
// fetch_unit: owns the fetch PC, issues word reads to instruction memory under a
// credit limit of QUEUE_DEPTH, buffers responses in an in-order queue and hands
// {word, PC} to decode over a valid/ready handshake. Redirects flush the queue and
// discard responses of reads that were already in flight.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (misaligned redirect flag + halt).

// Simulation-only checker: a memory response must always belong to an in-flight read.
module fetch_unit_checker #(
    parameter int CW = 2
) (
    input logic          clk,
    input logic          rst,
    input logic          rsp_valid,
    input logic [CW-1:0] inflight
);
    // A response while nothing is outstanding is an illegal memory behaviour.
    rsp_needs_inflight_a: assert property (@(posedge clk) disable iff (rst)
        rsp_valid |-> (inflight != '0));
endmodule

module fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          QUEUE_DEPTH  = 2
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    output logic        o_IMemReq,
    output logic [31:0] o_IMemAddr,
    input  logic        i_IMemGnt,
    input  logic        i_IMemRspValid,
    input  logic [31:0] i_IMemRspData,
    output logic        o_Valid,
    input  logic        i_Ready,
    output logic [31:0] o_InstructionWord,
    output logic [31:0] o_InstructionPC,
    input  logic        i_Redirect,
    input  logic [31:0] i_RedirectPC,
    output logic        o_FetchMisaligned
);
    localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;      // PC of the next non-dropped response
    logic [31:0]   word_q [QUEUE_DEPTH];
    logic [31:0]   word_d [QUEUE_DEPTH];
    logic [31:0]   qpc_q  [QUEUE_DEPTH];
    logic [31:0]   qpc_d  [QUEUE_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_q, drop_d;
    logic          halt_q, halt_d;

    logic [31:0]   target_s;
    logic          misalign_s;
    logic [CW:0]   used_s;
    logic          valid_s;
    logic          req_s;
    logic          gnt_s;
    logic          pop_s;
    logic          push_s;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign target_s          = i_RedirectPC;
    assign misalign_s        = (i_RedirectPC[1:0] != 2'b00);
    assign o_FetchMisaligned = halt_q && !i_Reset;
`else
    logic unused_rpc_s;
    assign unused_rpc_s      = ^i_RedirectPC[1:0];
    assign target_s          = {i_RedirectPC[31:2], 2'b00};
    assign misalign_s        = 1'b0;
    assign o_FetchMisaligned = 1'b0;
`endif

    assign used_s  = {1'b0, count_q} + {1'b0, inflight_q};
    assign valid_s = (count_q != '0);

    // Issue, handshake and response qualification for the current cycle.
    always_comb begin
        req_s  = 1'b0;
        if (!i_Reset && !i_Redirect && !halt_q && (used_s < (CW+1)'(QUEUE_DEPTH))) begin
            req_s = 1'b1;
        end else begin
            req_s = 1'b0;
        end
        gnt_s  = req_s && i_IMemGnt;
        pop_s  = valid_s && i_Ready;
        push_s = i_IMemRspValid && (drop_q == '0);
    end

    // Next-state computation for PC, queue, credit and drop accounting.
    always_comb begin
        pc_d       = pc_q;
        rsp_pc_d   = rsp_pc_q;
        word_d     = word_q;
        qpc_d      = qpc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        halt_d     = halt_q;
        if (i_Redirect) begin
            // No grant is possible here; everything still outstanding becomes stale.
            pc_d       = target_s;
            rsp_pc_d   = target_s;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            inflight_d = inflight_q - CW'(i_IMemRspValid);
            drop_d     = inflight_q - CW'(i_IMemRspValid);
            halt_d     = misalign_s;
        end else begin
            if (gnt_s) begin
                pc_d = pc_q + 32'd4;
            end else begin
                pc_d = pc_q;
            end
            inflight_d = inflight_q + CW'(gnt_s) - CW'(i_IMemRspValid);
            if (i_IMemRspValid && !push_s) begin
                drop_d = drop_q - CW'(1);
            end else begin
                drop_d = drop_q;
            end
            if (push_s) begin
                word_d[wr_ptr_q] = i_IMemRspData;
                qpc_d[wr_ptr_q]  = rsp_pc_q;
                wr_ptr_d         = wr_ptr_q + PW'(1);
                rsp_pc_d         = rsp_pc_q + 32'd4;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CW'(push_s) - CW'(pop_s);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            pc_q       <= RESET_VECTOR;
            rsp_pc_q   <= RESET_VECTOR;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
            halt_q     <= 1'b0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                word_q[i] <= 32'd0;
                qpc_q[i]  <= 32'd0;
            end
        end else begin
            pc_q       <= pc_d;
            rsp_pc_q   <= rsp_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            halt_q     <= halt_d;
            word_q     <= word_d;
            qpc_q      <= qpc_d;
        end
    end

    assign o_IMemReq         = req_s;
    assign o_IMemAddr        = pc_q;
    assign o_Valid           = valid_s && !i_Reset;
    assign o_InstructionWord = word_q[rd_ptr_q];
    assign o_InstructionPC   = qpc_q[rd_ptr_q];

    fetch_unit_checker #(.CW(CW)) u_checker (
        .clk       (i_Clock),
        .rst       (i_Reset),
        .rsp_valid (i_IMemRspValid),
        .inflight  (inflight_q)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: memory model with configurable latency, a queue-based
// reference model of the instruction stream, and directed scenarios.
module tb_fetch_unit;
    localparam logic [31:0] RV    = 32'h0000_0000;
    localparam int          DEPTH = 2;

    logic        i_Clock = 1'b0;
    logic        i_Reset = 1'b1;
    logic        o_IMemReq;
    logic [31:0] o_IMemAddr;
    logic        i_IMemGnt = 1'b0;
    logic        i_IMemRspValid = 1'b0;
    logic [31:0] i_IMemRspData = 32'd0;
    logic        o_Valid;
    logic        i_Ready = 1'b0;
    logic [31:0] o_InstructionWord;
    logic [31:0] o_InstructionPC;
    logic        i_Redirect = 1'b0;
    logic [31:0] i_RedirectPC = 32'd0;
    logic        o_FetchMisaligned;

    fetch_unit #(.RESET_VECTOR(RV), .QUEUE_DEPTH(DEPTH)) dut (
        .i_Clock(i_Clock), .i_Reset(i_Reset),
        .o_IMemReq(o_IMemReq), .o_IMemAddr(o_IMemAddr), .i_IMemGnt(i_IMemGnt),
        .i_IMemRspValid(i_IMemRspValid), .i_IMemRspData(i_IMemRspData),
        .o_Valid(o_Valid), .i_Ready(i_Ready),
        .o_InstructionWord(o_InstructionWord), .o_InstructionPC(o_InstructionPC),
        .i_Redirect(i_Redirect), .i_RedirectPC(i_RedirectPC),
        .o_FetchMisaligned(o_FetchMisaligned)
    );

    always #5 i_Clock = ~i_Clock;

    typedef struct { logic [31:0] addr; int due; } pend_t;
    typedef struct { logic [31:0] pc; bit stale; } infl_t;
    typedef struct { logic [31:0] word; logic [31:0] pc; } ent_t;

    pend_t pend[$];   // memory side: accepted reads awaiting response
    infl_t infl[$];   // model: outstanding reads in order
    ent_t  mq[$];     // model: queue contents visible to decode
    logic [31:0] m_pc = RV;
    bit          m_halt = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int lat = 1;
    bit gnt_en = 1'b1;
    bit s_req, s_gnt, s_valid;
    logic [31:0] s_addr, s_pc;
    event chk_ev;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison of DUT outputs against the reference model.
    always @(chk_ev) begin
        bit exp_valid, exp_req;
        exp_valid = !i_Reset && (mq.size() > 0);
        exp_req   = !i_Reset && !i_Redirect && !m_halt && ((mq.size() + infl.size()) < DEPTH);
        chk("o_Valid", {31'd0, o_Valid}, {31'd0, exp_valid});
        if (exp_valid) begin
            chk("o_InstructionPC", o_InstructionPC, mq[0].pc);
            chk("o_InstructionWord", o_InstructionWord, mq[0].word);
        end
        chk("o_IMemReq", {31'd0, o_IMemReq}, {31'd0, exp_req});
        if (exp_req) chk("o_IMemAddr", o_IMemAddr, m_pc);
        chk("o_FetchMisaligned", {31'd0, o_FetchMisaligned}, {31'd0, (!i_Reset && m_halt)});
    end

    task automatic cycle();
        bit rsp;
        logic [31:0] raddr;
        infl_t e;
        #1;
        s_req   = o_IMemReq;
        s_addr  = o_IMemAddr;
        s_valid = o_Valid;
        s_pc    = o_InstructionPC;
        s_gnt   = s_req && gnt_en;
        i_IMemGnt = s_gnt;
        rsp = 1'b0;
        raddr = 32'd0;
        if (!i_Reset && pend.size() > 0 && pend[0].due <= cyc) begin
            rsp = 1'b1;
            raddr = pend[0].addr;
            void'(pend.pop_front());
        end
        i_IMemRspValid = rsp;
        i_IMemRspData  = rsp ? memw(raddr) : 32'd0;
        #1;
        -> chk_ev;
        #1;
        // reference model update for this clock edge
        if (i_Reset) begin
            mq.delete(); infl.delete(); pend.delete();
            m_pc = RV; m_halt = 1'b0;
        end else if (i_Redirect) begin
            if (rsp) void'(infl.pop_front());
            foreach (infl[i]) infl[i].stale = 1'b1;
            mq.delete();
`ifdef FETCH_MISALIGN_CHECK_EN
            m_pc = i_RedirectPC;
            m_halt = (i_RedirectPC[1:0] != 2'b00);
`else
            m_pc = {i_RedirectPC[31:2], 2'b00};
`endif
        end else begin
            if (mq.size() > 0 && i_Ready) void'(mq.pop_front());
            if (rsp) begin
                e = infl.pop_front();
                if (!e.stale) mq.push_back('{memw(e.pc), e.pc});
            end
            if (s_gnt) begin
                infl.push_back('{m_pc, 1'b0});
                pend.push_back('{s_addr, cyc + lat});
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge i_Clock);
        @(negedge i_Clock);
        cyc++;
    endtask

    task automatic do_reset();
        i_Reset = 1'b1; i_Redirect = 1'b0;
        cycle(); cycle();
        i_Reset = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] t);
        i_Redirect = 1'b1; i_RedirectPC = t;
        cycle();
        i_Redirect = 1'b0;
    endtask

    initial begin
        int ng, g0, v0, nstale;
        logic [31:0] ga [3];
        logic [31:0] fpc;
        bit found;
        @(negedge i_Clock);

        // 1: latency 1, ready=1, sequential addresses and first-valid latency
        lat = 1; i_Ready = 1'b1; gnt_en = 1'b1;
        i_Reset = 1'b1;
        cycle();
        chk("reset_req", {31'd0, s_req}, 32'd0);
        chk("reset_valid", {31'd0, s_valid}, 32'd0);
        cycle();
        i_Reset = 1'b0;
        ng = 0; g0 = -1; v0 = -1;
        for (int i = 0; i < 14; i++) begin
            cycle();
            if (s_gnt && ng < 3) begin ga[ng] = s_addr; ng++; end
            if (s_gnt && g0 < 0) g0 = cyc - 1;
            if (s_valid && v0 < 0) v0 = cyc - 1;
        end
        chk("t1_addr0", ga[0], 32'h0);
        chk("t1_addr1", ga[1], 32'h4);
        chk("t1_addr2", ga[2], 32'h8);
        chk("t1_first_valid_latency", v0 - g0, 32'd2);

        // 2: ready low -> exactly DEPTH grants, head stays at PC 0
        do_reset();
        i_Ready = 1'b0; ng = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (s_gnt) ng++;
        end
        chk("t2_grants", ng, DEPTH);
        chk("t2_req_stopped", {31'd0, s_req}, 32'd0);
        chk("t2_head_pc", s_pc, 32'h0);
        i_Ready = 1'b1;
        for (int i = 0; i < 15; i++) cycle();

        // 3: latency 3, redirect with two reads in flight
        do_reset();
        lat = 3;
        cycle(); cycle();
        redirect(32'h100);
        found = 1'b0; fpc = 32'd0; nstale = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (s_valid && !found) begin found = 1'b1; fpc = s_pc; end
            if (s_valid && s_pc < 32'h100) nstale++;
        end
        chk("t3_first_pc", fpc, 32'h100);
        chk("t3_stale_seen", nstale, 32'd0);

        // 4: back-to-back redirects, last one wins
        do_reset();
        lat = 2;
        for (int i = 0; i < 4; i++) cycle();
        redirect(32'h200);
        redirect(32'h300);
        found = 1'b0; fpc = 32'd0; nstale = 0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (s_valid && !found) begin found = 1'b1; fpc = s_pc; end
            if (s_valid && s_pc < 32'h300) nstale++;
        end
        chk("t4_first_pc", fpc, 32'h300);
        chk("t4_stale_seen", nstale, 32'd0);

        // 5: reset mid-stream with a full queue
        do_reset();
        lat = 1; i_Ready = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        chk("t5_full_valid", {31'd0, s_valid}, 32'd1);
        i_Reset = 1'b1;
        cycle();
        chk("t5_reset_cycle_valid", {31'd0, s_valid}, 32'd0);
        chk("t5_reset_cycle_req", {31'd0, s_req}, 32'd0);
        i_Reset = 1'b0; i_Ready = 1'b1;
        cycle();
        chk("t5_after_valid", {31'd0, s_valid}, 32'd0);
        chk("t5_after_addr", s_addr, RV);
        chk("t5_after_req", {31'd0, s_req}, 32'd1);
        for (int i = 0; i < 12; i++) cycle();

        // 6: misaligned redirect target
        do_reset();
        redirect(32'h102);
`ifdef FETCH_MISALIGN_CHECK_EN
        cycle();
        chk("t6_flag", {31'd0, o_FetchMisaligned}, 32'd1);
        ng = (s_req ? 1 : 0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (s_req) ng++;
        end
        chk("t6_halted_reqs", ng, 32'd0);
        redirect(32'h104);
        cycle();
        chk("t6_flag_clear", {31'd0, o_FetchMisaligned}, 32'd0);
        chk("t6_resume_addr", s_addr, 32'h104);
        chk("t6_resume_req", {31'd0, s_req}, 32'd1);
`else
        cycle();
        chk("t6_aligned_addr", s_addr, 32'h100);
        chk("t6_req", {31'd0, s_req}, 32'd1);
        chk("t6_flag_tied", {31'd0, o_FetchMisaligned}, 32'd0);
`endif
        for (int i = 0; i < 10; i++) cycle();

        // 7: intermittent grant and ready with a redirect mid-stream
        do_reset();
        lat = 2;
        for (int i = 0; i < 40; i++) begin
            gnt_en  = (i % 3) != 0;
            i_Ready = (i % 2) == 0;
            if (i == 20) redirect(32'h1000);
            else cycle();
        end
        gnt_en = 1'b1; i_Ready = 1'b1;
        for (int i = 0; i < 10; i++) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
